// File: rtl/timer_pkg.sv
// Shared types and constants for the memory-mapped down-counter timer.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_MODE_MSB = 2;
    localparam int unsigned CTRL_IM       = 3;
    localparam int unsigned CTRL_PSC_LSB  = 4;
    localparam int unsigned CTRL_PSC_MSB  = 11;

    localparam int unsigned CTRL_W = CTRL_PSC_MSB + 1;
    localparam int unsigned MODE_W = CTRL_MODE_MSB - CTRL_MODE_LSB + 1;
    localparam int unsigned PSC_W  = CTRL_PSC_MSB - CTRL_PSC_LSB + 1;

    localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'd0;
    localparam logic [MODE_W-1:0] MODE_RELOAD  = 2'd1;

    // CTRL register layout, LSB first: en, mode, im, psc
    typedef struct packed {
        logic [PSC_W-1:0]  psc;
        logic              im;
        logic [MODE_W-1:0] mode;
        logic              en;
    } ctrl_t;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter timer with interrupt output.
// Optional prescaler on CTRL[11:4] is built when TIMER_PRESCALER_EN is defined.
module timer_counter
    import timer_pkg::*;
#(
    parameter logic [31:0]  BASE_ADDR = 32'h0000_7F00,
    parameter int unsigned  WIDTH     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_e             state_q, state_d;
    ctrl_t              ctrl_q, ctrl_d, ctrl_wr;
    logic [WIDTH-1:0]   preset_q, preset_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               flag_q, flag_d;
    logic               sel, wr, wr_ctrl, wr_preset;
    logic               psc_tick;
    logic               unused_addr;

    assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr          = sel && (byteen == 4'hF);
    assign wr_ctrl     = wr && (addr[3:2] == REG_CTRL);
    assign wr_preset   = wr && (addr[3:2] == REG_PRESET);
    assign unused_addr = ^addr[1:0];

    // Value a CTRL write would store; PSC field only exists with the prescaler
    always_comb begin
        ctrl_wr = ctrl_t'(wdata[CTRL_W-1:0]);
`ifndef TIMER_PRESCALER_EN
        ctrl_wr.psc = '0;
`endif
    end

`ifdef TIMER_PRESCALER_EN
    logic [PSC_W-1:0] psc_q;

    // Prescaler runs only while counting, so it restarts on LOAD and in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_q <= '0;
        end else if (state_q != ST_CNT || psc_tick) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_q + PSC_W'(1);
        end
    end

    assign psc_tick = (psc_q == ctrl_q.psc);
`else
    assign psc_tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    // Next-state logic; a bus CTRL write overrides any FSM update of CTRL/flag
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        if (wr_preset) begin
            preset_d = WIDTH'(wdata);
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (count_q != '0) begin
                    if (psc_tick) begin
                        count_d = count_q - WIDTH'(1);
                    end
                end else if (wr_ctrl && !ctrl_wr.en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INT;
                    flag_d  = 1'b1;
                end
            end
            ST_INT: begin
                // Reload folds into this edge so the auto-reload period is PRESET+2
                if (ctrl_q.mode == MODE_RELOAD) begin
                    count_d = preset_q;
                    flag_d  = 1'b0;
                    state_d = ST_CNT;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr_ctrl) begin
            ctrl_d = ctrl_wr;
            flag_d = 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr[3:2])
                REG_CTRL:   rdata = 32'(ctrl_q);
                REG_PRESET: rdata = 32'(preset_q);
                REG_COUNT:  rdata = 32'(count_q);
                default:    rdata = '0;
            endcase
        end
    end

    assign irq = flag_q & ctrl_q.im;

endmodule
